renamed_regfile_mp: RTL and testbench
=====================================

Name: renamed_regfile_mp

Overview:
- Parametrised, multi-port successor to the single-port renaming register file.
- Holds the architectural register values and, per register, a ROB tag (valid bit + ROB position) naming the in-flight producer.
- Serves NRD decoder read ports, one issue-rename port and NCMT in-order ROB commit ports per cycle.
- Tracks a live count of renamed registers for debug and stall heuristics.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- REG_W, 5, register index width; must satisfy 2^REG_W >= NREG.
- ROB_W, 4, ROB position width; stored tag is {valid, pos}, ROB_W+1 bits.
- NRD, 2, number of read ports.
- NCMT, 2, number of commit ports; port 0 is the oldest entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, no state changes.
- rollback  in  1  flush; clears all tags.
- rd_addr  in  NRD*REG_W  read indices; port k is bits [k*REG_W +: REG_W].
- rd_val  out  NRD*XLEN  read values.
- rd_tag  out  NRD*(ROB_W+1)  read tags; 0 means the value is ready.
- issue  in  1  rename strobe.
- issue_rd  in  REG_W  destination being renamed.
- issue_pos  in  ROB_W  ROB position of the renaming instruction.
- cmt_valid  in  NCMT  per-port commit strobe.
- cmt_rd  in  NCMT*REG_W  commit destinations.
- cmt_val  in  NCMT*XLEN  commit values.
- cmt_pos  in  NCMT*ROB_W  ROB positions of the committing entries.
- busy_cnt  out  REG_W+1  number of registers with a valid tag; registered.

Behaviour:
- Reset: when rst=1 at a clk edge, all values, all tags and busy_cnt go to 0, regardless of rdy or other inputs.
- After reset, every rd_val = 0, every rd_tag = 0 and busy_cnt = 0.
- Reads: combinational from stored state, with the optional bypass applied. Index 0 always returns val 0, tag 0. Indices >= NREG return 0/0.
- Commit (rdy=1), per port i with cmt_valid[i] and cmt_rd[i] != 0:
  - value[cmt_rd[i]] <= cmt_val[i].
  - The tag is cleared only if the current tag equals {1, cmt_pos[i]}.
- Same destination on several commit ports in one cycle: the highest-index (youngest) port's value wins. Each tag-clear test compares against the tag held before the edge.
- Issue (rdy=1, issue, issue_rd != 0): tag[issue_rd] <= {1, issue_pos}.
- Issue vs commit to the same register in the same cycle: the new issue tag wins; the committed value is still written.
- Rollback (rdy=1): all tags <= 0, overriding any issue or tag-clear in that cycle. Commit value writes in the same cycle still occur.
- busy_cnt: next value = popcount of the next-state tag valid bits. Equivalent to an incremental update (+1 on a fresh rename of a non-busy register, -1 per clear), recomputed so it never drifts. It reads 0 the cycle after a rollback.
- rdy=0: all state and busy_cnt hold; the read path remains live.
- Writes to register 0 are ignored on every path.

Optional Feature:
- Macro: RENAMED_REGFILE_CMT_BYPASS_EN.
- Defined: a read of register r with r != 0 that matches a same-cycle commit whose tag-clear test passes returns that commit's cmt_val with tag 0.
  - If several commits match, the youngest port is used.
  - The bypass is suppressed if the same cycle's issue targets r, because the returned tag must remain the stored tag until the edge.
- Undefined: reads return stored state only. A committed value is visible one cycle after the commit edge.

Test Plan:
- Reset then read x5 and x0 on both ports -> val 0 / tag 0; busy_cnt = 0.
- Issue x3 at pos 7; next cycle read x3 -> tag 5'h17, busy_cnt = 1. Commit x3 = 0xDEADBEEF at pos 7 -> one cycle later val 0xDEADBEEF, tag 0, busy_cnt = 0.
- Issue x3 at pos 2, then x3 at pos 9. Commit pos 2 with val 0x11 -> val 0x11, tag stays 5'h19, busy_cnt = 1.
- Same cycle: commit port 0 x4 = 0xA and port 1 x4 = 0xB, both tag-matching pos 1 -> x4 = 0xB, tag 0.
- Issue x6 at pos 4 in the same cycle as rollback with 3 other registers busy -> all tags 0, busy_cnt = 0, x6 tag 0.
- With the bypass macro: commit x8 = 0x55 at the matching pos while reading x8 -> same-cycle rd_val 0x55, tag 0. Without the macro: the old value and tag are shown until the edge.

Source files
------------

// File: rtl/renamed_regfile_mp.sv
// renamed_regfile_mp
//   Multi-port renaming register file. Each architectural register holds a
//   value plus a ROB tag {valid, pos} that names its in-flight producer.
//   Register 0 always reads as value 0, tag 0, and every write to it is
//   ignored.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     rdy              global enable; when low, state holds and reads stay live
//     rollback         clears every tag; overrides issue and tag clears
//     rd_addr/val/tag  NRD combinational read ports, packed per port
//     issue*           one rename port: tag[issue_rd] <= {1, issue_pos}
//     cmt_*            NCMT in-order commit ports; port 0 is the oldest
//     busy_cnt         registered count of registers holding a valid tag
//
//   Optional feature (macro RENAMED_REGFILE_CMT_BYPASS_EN):
//     When defined, a read of a register that matches a same-cycle commit
//     whose tag-clear test passes returns the commit value with tag 0. This
//     bypass is suppressed when the same cycle's issue renames that register.
//     When undefined, reads return stored state only.
module renamed_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCMT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic [NRD*REG_W-1:0]       rd_addr,
  output logic [NRD*XLEN-1:0]        rd_val,
  output logic [NRD*(ROB_W+1)-1:0]   rd_tag,
  input  logic                       issue,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic [ROB_W-1:0]           issue_pos,
  input  logic [NCMT-1:0]            cmt_valid,
  input  logic [NCMT*REG_W-1:0]      cmt_rd,
  input  logic [NCMT*XLEN-1:0]       cmt_val,
  input  logic [NCMT*ROB_W-1:0]      cmt_pos,
  output logic [REG_W:0]             busy_cnt
);

  localparam int TAG_W = ROB_W + 1;

  logic [XLEN-1:0]  val_q [NREG];
  logic [XLEN-1:0]  val_d [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [REG_W:0]   busy_cnt_q;
  logic [REG_W:0]   busy_cnt_d;

  // Next-state values, tags and busy count.
  // Tag-clear tests always compare against tag_q (the pre-edge tag), so
  // several commit ports to one register are each judged independently.
  // Ports are walked oldest to youngest so the youngest value wins.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      val_d[r] = val_q[r];
      tag_d[r] = tag_q[r];
      if (rdy && (r != 0)) begin
        for (int i = 0; i < NCMT; i++) begin
          if (cmt_valid[i] && (cmt_rd[i*REG_W +: REG_W] == REG_W'(r))) begin
            val_d[r] = cmt_val[i*XLEN +: XLEN];
            if (tag_q[r] == {1'b1, cmt_pos[i*ROB_W +: ROB_W]}) begin
              tag_d[r] = '0;
            end else begin
              tag_d[r] = tag_d[r];
            end
          end else begin
            val_d[r] = val_d[r];
          end
        end
        // A fresh rename beats a same-cycle clear of the older producer.
        if (issue && (issue_rd == REG_W'(r))) begin
          tag_d[r] = {1'b1, issue_pos};
        end else begin
          tag_d[r] = tag_d[r];
        end
        // Rollback wipes all tags but leaves committed values in place.
        if (rollback) begin
          tag_d[r] = '0;
        end else begin
          tag_d[r] = tag_d[r];
        end
      end else begin
        val_d[r] = val_q[r];
        tag_d[r] = tag_q[r];
      end
      // Recount from the next-state tags every cycle so the count cannot drift.
      busy_cnt_d = busy_cnt_d + {{REG_W{1'b0}}, tag_d[r][ROB_W]};
    end
  end

  // Read ports: stored state, optionally overridden by a same-cycle commit.
  always_comb begin
    rd_val = '0;
    rd_tag = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_addr[k*REG_W +: REG_W] == REG_W'(r)) begin
          rd_val[k*XLEN +: XLEN]   = val_q[r];
          rd_tag[k*TAG_W +: TAG_W] = tag_q[r];
`ifdef RENAMED_REGFILE_CMT_BYPASS_EN
          if (rdy && !(issue && (issue_rd == REG_W'(r)))) begin
            for (int i = 0; i < NCMT; i++) begin
              if (cmt_valid[i] && (cmt_rd[i*REG_W +: REG_W] == REG_W'(r)) &&
                  (tag_q[r] == {1'b1, cmt_pos[i*ROB_W +: ROB_W]})) begin
                rd_val[k*XLEN +: XLEN]   = cmt_val[i*XLEN +: XLEN];
                rd_tag[k*TAG_W +: TAG_W] = '0;
              end else begin
                rd_val[k*XLEN +: XLEN]   = rd_val[k*XLEN +: XLEN];
              end
            end
          end else begin
            rd_tag[k*TAG_W +: TAG_W] = tag_q[r];
          end
`endif
        end else begin
          rd_val[k*XLEN +: XLEN] = rd_val[k*XLEN +: XLEN];
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_renamed_regfile_mp.sv
module tb_renamed_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;
  localparam int NRD   = 2;
  localparam int NCMT  = 2;
  localparam int TAG_W = ROB_W + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     rdy = 1'b0;
  logic                     rollback = 1'b0;
  logic [NRD*REG_W-1:0]     rd_addr = '0;
  logic [NRD*XLEN-1:0]      rd_val;
  logic [NRD*TAG_W-1:0]     rd_tag;
  logic                     issue = 1'b0;
  logic [REG_W-1:0]         issue_rd = '0;
  logic [ROB_W-1:0]         issue_pos = '0;
  logic [NCMT-1:0]          cmt_valid = '0;
  logic [NCMT*REG_W-1:0]    cmt_rd = '0;
  logic [NCMT*XLEN-1:0]     cmt_val = '0;
  logic [NCMT*ROB_W-1:0]    cmt_pos = '0;
  logic [REG_W:0]           busy_cnt;

  renamed_regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W), .NRD(NRD), .NCMT(NCMT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rd_addr(rd_addr), .rd_val(rd_val), .rd_tag(rd_tag),
    .issue(issue), .issue_rd(issue_rd), .issue_pos(issue_pos),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_pos(cmt_pos),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0]  val;
    logic [NRD*TAG_W-1:0] tag;
    logic [REG_W:0]       cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: plain per-register value, busy flag and producer position.
  logic [XLEN-1:0]  m_val  [NREG];
  bit               m_busy [NREG];
  logic [ROB_W-1:0] m_pos  [NREG];
  bit               m_known = 1'b0;

  function automatic logic [REG_W:0] m_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) if (m_busy[r]) n++;
    return (REG_W+1)'(n);
  endfunction

  function automatic void model_read(input int a, output logic [XLEN-1:0] v,
                                     output logic [TAG_W-1:0] t);
    v = '0;
    t = '0;
    if (a == 0 || a >= NREG) return;
    v = m_val[a];
    t = m_busy[a] ? {1'b1, m_pos[a]} : '0;
`ifdef RENAMED_REGFILE_CMT_BYPASS_EN
    if (rdy && !(issue && int'(issue_rd) == a)) begin
      for (int i = 0; i < NCMT; i++) begin
        if (cmt_valid[i] && int'(cmt_rd[i*REG_W +: REG_W]) == a &&
            m_busy[a] && m_pos[a] == cmt_pos[i*ROB_W +: ROB_W]) begin
          v = cmt_val[i*XLEN +: XLEN];
          t = '0;
        end
      end
    end
`endif
  endfunction

  function automatic void model_update();
    bit clr [NREG];
    int a;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_val[r] = '0; m_busy[r] = 1'b0; m_pos[r] = '0;
      end
      m_known = 1'b1;
      return;
    end
    if (!rdy) return;
    for (int r = 0; r < NREG; r++) clr[r] = 1'b0;
    for (int i = 0; i < NCMT; i++) begin
      a = int'(cmt_rd[i*REG_W +: REG_W]);
      if (cmt_valid[i] && a != 0 && a < NREG) begin
        m_val[a] = cmt_val[i*XLEN +: XLEN];
        if (m_busy[a] && m_pos[a] == cmt_pos[i*ROB_W +: ROB_W]) clr[a] = 1'b1;
      end
    end
    for (int r = 0; r < NREG; r++) if (clr[r]) m_busy[r] = 1'b0;
    a = int'(issue_rd);
    if (issue && a != 0 && a < NREG) begin
      m_busy[a] = 1'b1;
      m_pos[a]  = issue_pos;
    end
    if (rollback) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
  endfunction

  // Start a cycle: just after the edge, return every input to idle.
  task automatic next();
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; issue_rd = '0; issue_pos = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_val = '0; cmt_pos = '0; rd_addr = '0;
  endtask

  // Inputs for this cycle are final: queue the expected outputs, then advance the model.
  task automatic sample();
    exp_t e;
    logic [XLEN-1:0]  v;
    logic [TAG_W-1:0] t;
    if (m_known) begin
      for (int k = 0; k < NRD; k++) begin
        model_read(int'(rd_addr[k*REG_W +: REG_W]), v, t);
        e.val[k*XLEN +: XLEN]   = v;
        e.tag[k*TAG_W +: TAG_W] = t;
      end
      e.cnt = m_count();
      sb_q.push_back(e);
    end
    model_update();
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {REG_W'(a1), REG_W'(a0)};
  endtask

  task automatic set_iss(input int r, input int pos);
    issue = 1'b1; issue_rd = REG_W'(r); issue_pos = ROB_W'(pos);
  endtask

  task automatic set_cmt(input int i, input int r, input logic [XLEN-1:0] v, input int pos);
    cmt_valid[i] = 1'b1;
    cmt_rd[i*REG_W +: REG_W] = REG_W'(r);
    cmt_val[i*XLEN +: XLEN]  = v;
    cmt_pos[i*ROB_W +: ROB_W] = ROB_W'(pos);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents read data and busy_cnt every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < NRD; k++) begin
          chk($sformatf("sb_val[%0d]", k), 64'(rd_val[k*XLEN +: XLEN]), 64'(e.val[k*XLEN +: XLEN]));
          chk($sformatf("sb_tag[%0d]", k), 64'(rd_tag[k*TAG_W +: TAG_W]), 64'(e.tag[k*TAG_W +: TAG_W]));
        end
        chk("sb_busy_cnt", 64'(busy_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    int r;
    // Reset: first cycle has unknown prior state, so nothing is queued for it.
    next(); rst = 1'b1; sample();
    next(); set_rd(5, 0); sample();
    @(negedge clk);
    chk("rst_val", 64'(rd_val), 64'd0);
    chk("rst_tag", 64'(rd_tag), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);
    next(); set_rd(0, 5); sample();
    @(negedge clk);
    chk("rst_val_swap", 64'(rd_val), 64'd0);
    chk("rst_tag_swap", 64'(rd_tag), 64'd0);

    // Rename x3 then commit it.
    next(); set_iss(3, 7); sample();
    next(); set_rd(3, 3); sample();
    @(negedge clk);
    chk("iss_tag", 64'(rd_tag[TAG_W-1:0]), 64'h17);
    chk("iss_busy", 64'(busy_cnt), 64'd1);
    next(); set_cmt(0, 3, 32'hDEADBEEF, 7); set_rd(3, 0); sample();
    next(); set_rd(3, 3); sample();
    @(negedge clk);
    chk("cmt_val", 64'(rd_val[XLEN-1:0]), 64'hDEADBEEF);
    chk("cmt_tag", 64'(rd_tag[TAG_W-1:0]), 64'h0);
    chk("cmt_busy", 64'(busy_cnt), 64'd0);

    // Stale commit keeps the younger producer's tag.
    next(); set_iss(3, 2); sample();
    next(); set_iss(3, 9); sample();
    next(); set_cmt(0, 3, 32'h11, 2); sample();
    next(); set_rd(3, 3); sample();
    @(negedge clk);
    chk("stale_val", 64'(rd_val[XLEN-1:0]), 64'h11);
    chk("stale_tag", 64'(rd_tag[TAG_W-1:0]), 64'h19);
    chk("stale_busy", 64'(busy_cnt), 64'd1);

    // Two commit ports to one register: youngest value wins.
    next(); set_iss(4, 1); sample();
    next(); set_cmt(0, 4, 32'hA, 1); set_cmt(1, 4, 32'hB, 1); sample();
    next(); set_rd(4, 4); sample();
    @(negedge clk);
    chk("dual_val", 64'(rd_val[XLEN-1:0]), 64'hB);
    chk("dual_tag", 64'(rd_tag[TAG_W-1:0]), 64'h0);

    // Rollback overrides a same-cycle issue.
    next(); set_iss(10, 3); sample();
    next(); set_iss(11, 5); sample();
    next(); set_iss(12, 6); sample();
    next(); set_iss(6, 4); rollback = 1'b1; sample();
    next(); set_rd(6, 10); sample();
    @(negedge clk);
    chk("rb_tag6", 64'(rd_tag[TAG_W-1:0]), 64'h0);
    chk("rb_tag10", 64'(rd_tag[2*TAG_W-1:TAG_W]), 64'h0);
    chk("rb_busy", 64'(busy_cnt), 64'd0);

    // rdy low: nothing changes.
    next(); rdy = 1'b0; set_iss(9, 3); set_cmt(0, 9, 32'h7, 3); sample();
    next(); set_rd(9, 9); sample();
    @(negedge clk);
    chk("rdy0_val", 64'(rd_val[XLEN-1:0]), 64'h0);
    chk("rdy0_busy", 64'(busy_cnt), 64'd0);

    // Same-cycle commit visibility on the read path.
    next(); set_iss(8, 5); sample();
    next(); set_cmt(0, 8, 32'h55, 5); set_rd(8, 0); sample();
    @(negedge clk);
`ifdef RENAMED_REGFILE_CMT_BYPASS_EN
    chk("byp_val", 64'(rd_val[XLEN-1:0]), 64'h55);
    chk("byp_tag", 64'(rd_tag[TAG_W-1:0]), 64'h0);
`else
    chk("nobyp_val", 64'(rd_val[XLEN-1:0]), 64'h0);
    chk("nobyp_tag", 64'(rd_tag[TAG_W-1:0]), 64'h15);
`endif
    next(); set_rd(8, 8); sample();
    @(negedge clk);
    chk("post_cmt_val", 64'(rd_val[XLEN-1:0]), 64'h55);

    // Randomized traffic, biased to a few registers so ports collide.
    for (int c = 0; c < 3000; c++) begin
      next();
      rst      = ($urandom_range(0, 199) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) set_iss($urandom_range(0, 7), $urandom_range(0, 15));
      for (int i = 0; i < NCMT; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          set_cmt(i, r, $urandom(),
                  ($urandom_range(0, 2) != 0 && m_busy[r]) ? int'(m_pos[r]) : $urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 1) == 1) set_rd(int'(cmt_rd[REG_W-1:0]), $urandom_range(0, 31));
      else set_rd($urandom_range(0, 7), int'(issue_rd));
      sample();
    end

    @(negedge clk); #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
